pitch_resample: RTL and testbench

Post-processing stage downstream of the pitch core in pitch-shift mode. It reads a time-stretched clip from SDRAM, resamples it by `speed/8` with per-channel linear interpolation, and writes the result plus a fresh header to a target clip. The pitch core then only performs the stretch, and the shift is completed here. The block shares the pitch core's SDRAM request/finished handshake and sits behind the same arbiter port.

---
 rtl/pitch_resample_if.sv | 38 +++
 rtl/pitch_resample.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pitch_resample.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pitch_resample_if.sv
// pitch_resample_if: control and SDRAM request/finished bus of pitch_resample.
//   master : the resampler (drives SDRAM requests and the done pulse)
//   slave  : controller / arbiter port (drives start, config and SDRAM replies)
// Signals:
//   resample_start/src/dst/speed   job request and parameters
//   resample_done                  one-cycle completion pulse
//   resample_read/write/addr       SDRAM request (held until finished)
//   resample_writedata/readdata    32-bit sample pair, L=[31:16], R=[15:0]
//   resample_sdram_finished        transaction complete, read data valid
interface pitch_resample_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              resample_start;
  logic [ADDR_W-1:0] resample_src;
  logic [ADDR_W-1:0] resample_dst;
  logic [3:0]        resample_speed;
  logic              resample_done;
  logic              resample_read;
  logic              resample_write;
  logic [ADDR_W-1:0] resample_addr;
  logic [31:0]       resample_readdata;
  logic [31:0]       resample_writedata;
  logic              resample_sdram_finished;

  modport master (
    input  resample_start, resample_src, resample_dst, resample_speed,
    input  resample_readdata, resample_sdram_finished,
    output resample_done, resample_read, resample_write,
    output resample_addr, resample_writedata
  );

  modport slave (
    output resample_start, resample_src, resample_dst, resample_speed,
    output resample_readdata, resample_sdram_finished,
    input  resample_done, resample_read, resample_write,
    input  resample_addr, resample_writedata
  );
endinterface

// File: rtl/pitch_resample.sv
// pitch_resample: reads a time-stretched clip from SDRAM, resamples it by
// speed/8 and writes the result plus a new header to a destination clip.
// Ports:
//   i_clk  sole clock
//   i_rst  asynchronous active-high reset
//   bus    pitch_resample_if.master (start/config, done, SDRAM handshake)
// Build option:
//   PITCH_RESAMPLE_INTERP_EN defined   -> per-channel linear interpolation
//   PITCH_RESAMPLE_INTERP_EN undefined -> nearest-lower sample (out = s0)
module pitch_resample #(
  parameter int unsigned ADDR_W = 23
) (
  input logic              i_clk,
  input logic              i_rst,
  pitch_resample_if.master bus
);

  localparam int unsigned POS_W = ADDR_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HDR,
    S_FETCH0,
    S_FETCH1,
    S_WR_DATA,
    S_WR_HDR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        speed_q, speed_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [31:0]       s0_q, s0_d;
  logic [ADDR_W-1:0] c0_idx_q, c0_idx_d;
  logic              c0_vld_q, c0_vld_d;
`ifdef PITCH_RESAMPLE_INTERP_EN
  logic [31:0]       s1_q, s1_d;
  logic [ADDR_W-1:0] c1_idx_q, c1_idx_d;
  logic              c1_vld_q, c1_vld_d;
  logic              last_n;
  logic [31:0]       s1_eff;
`endif

  logic              req;
  logic              finished;
  logic              dispatch;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_n;
  logic [31:0]       out_w;

  assign req      = read_q | write_q;
  assign finished = req & bus.resample_sdram_finished;
  assign idx_q    = pos_q[POS_W-1:3];

`ifdef PITCH_RESAMPLE_INTERP_EN
  // s0 + floor(((s1 - s0) * frac) / 8); result stays between s0 and s1.
  function automatic logic [15:0] lerp16(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [2:0]  f);
    logic signed [16:0] diff;
    logic signed [20:0] prod;
    logic signed [20:0] sh;
    diff = $signed({b[15], b}) - $signed({a[15], a});
    prod = diff * $signed({1'b0, f});
    sh   = prod >>> 3;
    return a + sh[15:0];
  endfunction

  // The last sample interpolates against itself; no fetch past the clip.
  assign s1_eff = ((idx_q + ADDR_W'(1)) == len_q) ? s0_q : s1_q;
  assign out_w  = {lerp16(s0_q[31:16], s1_eff[31:16], pos_q[2:0]),
                   lerp16(s0_q[15:0],  s1_eff[15:0],  pos_q[2:0])};
`else
  assign out_w  = s0_q;
`endif

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    write_d  = write_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    speed_d  = speed_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    k_d      = k_q;
    pos_d    = pos_q;
    s0_d     = s0_q;
    c0_idx_d = c0_idx_q;
    c0_vld_d = c0_vld_q;
`ifdef PITCH_RESAMPLE_INTERP_EN
    s1_d     = s1_q;
    c1_idx_d = c1_idx_q;
    c1_vld_d = c1_vld_q;
    last_n   = 1'b0;
`endif
    dispatch = 1'b0;
    idx_n    = '0;

    // Bus states raise their request only while req is low, so each
    // finished is followed by at least one idle request cycle.
    case (state_q)
      S_IDLE: begin
        if (bus.resample_start) begin
          speed_d  = bus.resample_speed;
          src_d    = bus.resample_src;
          dst_d    = bus.resample_dst;
          k_d      = '0;
          pos_d    = '0;
          c0_vld_d = 1'b0;
`ifdef PITCH_RESAMPLE_INTERP_EN
          c1_vld_d = 1'b0;
`endif
          read_d   = 1'b1;
          addr_d   = bus.resample_src;
          state_d  = S_RD_HDR;
        end
      end
      S_RD_HDR: begin
        if (finished) begin
          read_d = 1'b0;
          len_d  = bus.resample_readdata[31:9];
          if (len_d == '0 || speed_q == 4'd0) state_d = S_WR_HDR;
          else                                 dispatch = 1'b1;
        end
      end
      S_FETCH0: begin
        if (!req) begin
          read_d = 1'b1;
          addr_d = src_q + ADDR_W'(1) + idx_q;
        end else if (finished) begin
          read_d   = 1'b0;
          s0_d     = bus.resample_readdata;
          c0_idx_d = idx_q;
          c0_vld_d = 1'b1;
          dispatch = 1'b1;
        end
      end
`ifdef PITCH_RESAMPLE_INTERP_EN
      S_FETCH1: begin
        if (!req) begin
          read_d = 1'b1;
          addr_d = src_q + ADDR_W'(2) + idx_q;
        end else if (finished) begin
          read_d   = 1'b0;
          s1_d     = bus.resample_readdata;
          c1_idx_d = idx_q + ADDR_W'(1);
          c1_vld_d = 1'b1;
          dispatch = 1'b1;
        end
      end
`endif
      S_WR_DATA: begin
        if (!req) begin
          write_d = 1'b1;
          addr_d  = dst_q + ADDR_W'(1) + k_q;
          wdata_d = out_w;
        end else if (finished) begin
          write_d  = 1'b0;
          k_d      = k_q + ADDR_W'(1);
          pos_d    = pos_q + POS_W'(speed_q);
          dispatch = 1'b1;
        end
      end
      S_WR_HDR: begin
        if (!req) begin
          write_d = 1'b1;
          addr_d  = dst_q;
          wdata_d = {k_q, 9'b0};
        end else if (finished) begin
          write_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Decide the next step from the updated position, count and cache;
    // shared by every transaction that completes inside the output loop.
    if (dispatch) begin
      idx_n = pos_d[POS_W-1:3];
`ifdef PITCH_RESAMPLE_INTERP_EN
      last_n = (idx_n + ADDR_W'(1)) == len_d;
`endif
      if (idx_n >= len_d || k_d == '1) begin
        state_d = S_WR_HDR;
      end else if (c0_vld_d && c0_idx_d == idx_n) begin
`ifdef PITCH_RESAMPLE_INTERP_EN
        if (last_n || (c1_vld_d && c1_idx_d == idx_n + ADDR_W'(1)))
          state_d = S_WR_DATA;
        else
          state_d = S_FETCH1;
`else
        state_d = S_WR_DATA;
`endif
`ifdef PITCH_RESAMPLE_INTERP_EN
      end else if (c1_vld_d && c1_idx_d == idx_n) begin
        s0_d     = s1_d;
        c0_idx_d = c1_idx_d;
        c0_vld_d = 1'b1;
        c1_vld_d = 1'b0;
        state_d  = last_n ? S_WR_DATA : S_FETCH1;
`endif
      end else begin
        state_d = S_FETCH0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      speed_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      k_q      <= '0;
      pos_q    <= '0;
      s0_q     <= '0;
      c0_idx_q <= '0;
      c0_vld_q <= 1'b0;
`ifdef PITCH_RESAMPLE_INTERP_EN
      s1_q     <= '0;
      c1_idx_q <= '0;
      c1_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      write_q  <= write_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      speed_q  <= speed_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      k_q      <= k_d;
      pos_q    <= pos_d;
      s0_q     <= s0_d;
      c0_idx_q <= c0_idx_d;
      c0_vld_q <= c0_vld_d;
`ifdef PITCH_RESAMPLE_INTERP_EN
      s1_q     <= s1_d;
      c1_idx_q <= c1_idx_d;
      c1_vld_q <= c1_vld_d;
`endif
    end
  end

  assign bus.resample_done      = done_q;
  assign bus.resample_read      = read_q;
  assign bus.resample_write     = write_q;
  assign bus.resample_addr      = addr_q;
  assign bus.resample_writedata = wdata_q;

endmodule

// File: tb/tb_pitch_resample.sv
// tb_pitch_resample: directed bench for pitch_resample with an SDRAM model
// that answers after a random 0-7 cycle delay and a scoreboard of the
// expected write stream (data words then header) for every job.
module tb_pitch_resample;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pitch_resample_if #(.ADDR_W(23)) bus ();

  pitch_resample #(.ADDR_W(23)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [31:0] mem [int unsigned];
  logic [54:0] exp_q [$];

  int n_assert = 0;
  int n_fail   = 0;
  int reads_cnt = 0;
  int forbid_cnt = 0;
  int done_cnt = 0;
  logic [22:0] cur_dst = '0;
  logic [22:0] forbid_addr = '1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd(input logic [22:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return '0;
  endfunction

`ifdef PITCH_RESAMPLE_INTERP_EN
  function automatic logic [15:0] tb_lerp(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] f);
    int sa, sb, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = (sb - sa) * int'(f);
    p  = p >>> 3;
    return 16'(sa + p);
  endfunction
`endif

  // Reference model: expected writes straight from the resampling rule.
  task automatic push_expected(input logic [22:0] src, input logic [22:0] dst,
                               input logic [3:0] spd);
    logic [31:0] hdr, w0, w1, outw;
    logic [22:0] len, idx, kk;
    logic [25:0] pos;
    logic [2:0]  f;
    hdr = rd(src);
    len = hdr[31:9];
    kk  = '0;
    pos = '0;
    if (len != 0 && spd != 0) begin
      while (pos[25:3] < len) begin
        idx = pos[25:3];
        f   = pos[2:0];
        w0  = rd(src + 23'd1 + idx);
        w1  = (idx + 23'd1 == len) ? w0 : rd(src + 23'd2 + idx);
`ifdef PITCH_RESAMPLE_INTERP_EN
        outw = {tb_lerp(w0[31:16], w1[31:16], f), tb_lerp(w0[15:0], w1[15:0], f)};
`else
        outw = w0;
`endif
        exp_q.push_back({dst + 23'd1 + kk, outw});
        kk  = kk + 23'd1;
        pos = pos + 26'(spd);
      end
    end
    exp_q.push_back({dst, kk, 9'b0});
  endtask

  // SDRAM responder and protocol monitor, evaluated on the falling edge.
  int unsigned wait_cnt = 0;
  int unsigned delay = 0;
  bit cap_v = 1'b0;
  bit hdr_pend = 1'b0;
  logic [22:0] cap_a = '0;
  logic [31:0] cap_d = '0;
  logic [54:0] e;

  always @(negedge clk) begin
    if (rst) begin
      bus.resample_sdram_finished = 1'b0;
      wait_cnt = 0;
      cap_v    = 1'b0;
      hdr_pend = 1'b0;
    end else begin
      if (hdr_pend) begin
        chk("done_latency", bus.resample_done, 1);
        hdr_pend = 1'b0;
      end
      chk("rd_wr_exclusive", bus.resample_read & bus.resample_write, 0);
      if (bus.resample_done) done_cnt++;
      if (bus.resample_sdram_finished) begin
        bus.resample_sdram_finished = 1'b0;
        wait_cnt = 0;
        cap_v    = 1'b0;
        chk("req_drop", bus.resample_read | bus.resample_write, 0);
      end else if (bus.resample_read | bus.resample_write) begin
        if (!cap_v) begin
          cap_v    = 1'b1;
          cap_a    = bus.resample_addr;
          cap_d    = bus.resample_writedata;
          delay    = $urandom_range(7, 0);
          wait_cnt = 0;
        end else begin
          chk("addr_stable", bus.resample_addr, cap_a);
          if (bus.resample_write) chk("wdata_stable", bus.resample_writedata, cap_d);
        end
        if (wait_cnt == delay) begin
          bus.resample_sdram_finished = 1'b1;
          if (bus.resample_read) begin
            bus.resample_readdata = rd(bus.resample_addr);
            reads_cnt++;
            if (bus.resample_addr == forbid_addr) forbid_cnt++;
          end else begin
            mem[32'(bus.resample_addr)] = bus.resample_writedata;
            if (exp_q.size() == 0) begin
              chk("sb_unexpected_write", {9'b0, bus.resample_addr, bus.resample_writedata}, '1);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", bus.resample_addr, e[54:32]);
              chk("wr_data", bus.resample_writedata, e[31:0]);
            end
            if (bus.resample_addr == cur_dst) hdr_pend = 1'b1;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic start_run(input logic [22:0] src, input logic [22:0] dst, input logic [3:0] spd);
    push_expected(src, dst, spd);
    cur_dst    = dst;
    reads_cnt  = 0;
    forbid_cnt = 0;
    @(negedge clk);
    bus.resample_start = 1'b1;
    bus.resample_src   = src;
    bus.resample_dst   = dst;
    bus.resample_speed = spd;
    @(posedge clk);
    #1;
    chk("start_latency_read", bus.resample_read, 1);
    chk("hdr_read_addr", bus.resample_addr, src);
    @(negedge clk);
    bus.resample_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_reads, input bit mid_start);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 4000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc == 10) begin
        bus.resample_start = 1'b1;
        bus.resample_src   = 23'h000123;
        bus.resample_dst   = 23'h000777;
        bus.resample_speed = 4'd1;
      end else begin
        bus.resample_start = 1'b0;
      end
      if (bus.resample_done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.resample_done, 0);
    chk("read_count", reads_cnt, exp_reads);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    bit found;
    bus.resample_start          = 1'b0;
    bus.resample_src            = '0;
    bus.resample_dst            = '0;
    bus.resample_speed          = '0;
    bus.resample_readdata       = '0;
    bus.resample_sdram_finished = 1'b0;

    // Source clips
    mem[100] = {23'd4, 9'd0};
    for (int i = 1; i <= 4; i++) mem[100 + i] = {16'(i), 16'(i)};
    mem[200] = {23'd2, 9'd0};
    mem[201] = {16'd0, 16'd0};
    mem[202] = {16'd800, 16'hFCE0};
    mem[300] = {23'd4, 9'd0};
    mem[301] = {16'd0, 16'd0};
    mem[302] = {16'd100, 16'hFFF9};
    mem[303] = {16'd200, 16'd5};
    mem[304] = {16'd300, 16'hFED4};
    mem[400] = 32'h0000_01FF;
    mem[500] = {23'd5, 9'd0};
    for (int i = 1; i <= 5; i++) mem[500 + i] = {16'(10 * i), 16'(7 * i)};
    mem[32'h7FFFFE] = {23'd3, 9'd0};
    mem[32'h7FFFFF] = {16'h7FFF, 16'h8000};
    mem[0]          = {16'h8000, 16'h7FFF};
    mem[1]          = {16'd1, 16'd2};

    repeat (2) @(negedge clk);
    chk("rst_read", bus.resample_read, 0);
    chk("rst_write", bus.resample_write, 0);
    chk("rst_done", bus.resample_done, 0);
    chk("rst_addr", bus.resample_addr, 0);
    chk("rst_wdata", bus.resample_writedata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Unity speed, with a start pulse injected mid-run
    start_run(23'd100, 23'd1000, 4'd8);
    wait_done(5, 1'b1);

    // Upsample by two
    start_run(23'd200, 23'd1100, 4'd4);
    wait_done(3, 1'b0);

    // Non-integer step; index 2 is only ever an s1 fetch
    forbid_addr = 23'd303;
    start_run(23'd300, 23'd1200, 4'd12);
`ifdef PITCH_RESAMPLE_INTERP_EN
    wait_done(5, 1'b0);
    chk("s1_only_read_count", forbid_cnt, 1);
`else
    wait_done(4, 1'b0);
    chk("no_idx_plus1_read", forbid_cnt, 0);
`endif
    forbid_addr = '1;

    // Empty clip and zero speed
    start_run(23'd400, 23'd1300, 4'd8);
    wait_done(1, 1'b0);
    start_run(23'd500, 23'd1350, 4'd0);
    wait_done(1, 1'b0);

    // Source wrapping around the top of the address space
    start_run(23'h7FFFFE, 23'd50, 4'd5);
    wait_done(4, 1'b0);

    // Reset while fetching sample index 1 of a running job
    start_run(23'd300, 23'd1400, 4'd12);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (bus.resample_read && bus.resample_addr == 23'd302) found = 1'b1;
    end
    chk("rst_trigger_found", found, 1);
    rst = 1'b1;
    #1;
    chk("midrst_read", bus.resample_read, 0);
    chk("midrst_write", bus.resample_write, 0);
    chk("midrst_addr", bus.resample_addr, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);

    // Clean rerun after the abort
    start_run(23'd200, 23'd1500, 4'd4);
    wait_done(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
